// File: rtl/reservoir_delay_line.sv
// Virtual-node delay loop of the DFR: shift chain, random access, frame counter
// and a handshaked bulk dump of every node state.
module reservoir_delay_line #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_NODES  = 50,
  localparam int ADDR_WIDTH = $clog2(NUM_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_din,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] node_idx,
  output logic                  frame_done,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_idx
);

  typedef enum logic {
    S_IDLE,
    S_DUMP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(NUM_NODES - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_node [NUM_NODES];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH-1:0] r_node_idx;
  logic                  r_frame_done;
  logic                  r_dump_valid;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic [ADDR_WIDTH-1:0] r_dump_idx;

  logic                  w_idle;
  logic                  w_shift;
  logic                  w_load;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_dump_inc;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic [DATA_WIDTH-1:0] w_dump_mux;

  // Nodes are frozen while a dump is streaming.
  assign w_idle     = (r_state == S_IDLE);
  assign w_shift    = shift_en && w_idle;
  assign w_load     = load_en && !shift_en && w_idle;
  assign w_xfer     = r_dump_valid && dump_ready;
  assign w_dump_inc = r_dump_idx + 1'b1;

  // Node selects; out-of-range addresses match no node and read as zero.
  always_comb begin
    w_rd_mux   = '0;
    w_dump_mux = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (rd_addr == ADDR_WIDTH'(i))
        w_rd_mux = r_node[i];
      if (w_dump_inc == ADDR_WIDTH'(i))
        w_dump_mux = r_node[i];
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Dump FSM next state; clear beats a start and aborts a running dump.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (dump_start && !clear)
          w_state_nxt = S_DUMP;
      end
      S_DUMP: begin
        if (clear)
          w_state_nxt = S_IDLE;
        else if (w_xfer && r_dump_idx == LP_LAST)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Node storage: clear, then shift, then addressed load.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_NODES; i++)
        r_node[i] <= '0;
    end else if (w_shift) begin
      r_node[0] <= din;
      for (int i = 1; i < NUM_NODES; i++)
        r_node[i] <= r_node[i-1];
    end else if (w_load) begin
      for (int i = 0; i < NUM_NODES; i++)
        if (load_addr == ADDR_WIDTH'(i))
          r_node[i] <= load_din;
    end
  end

  // Registered read-back of the pre-update node value.
  always_ff @(posedge clk) begin
    if (rst)
      r_rd_data <= '0;
    else
      r_rd_data <= w_rd_mux;
  end

  // Virtual-node index with a pulse on the wrapping shift.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_node_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_shift) begin
        if (r_node_idx == LP_LAST) begin
          r_node_idx   <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_node_idx <= r_node_idx + 1'b1;
        end
      end
    end
  end

  // Dump stream registers; data and index hold while stalled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_idx   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (dump_start) begin
            r_dump_valid <= 1'b1;
            r_dump_idx   <= '0;
            r_dump_data  <= r_node[0];
          end
        end
        S_DUMP: begin
          if (w_xfer) begin
            if (r_dump_idx == LP_LAST) begin
              r_dump_valid <= 1'b0;
            end else begin
              r_dump_idx  <= w_dump_inc;
              r_dump_data <= w_dump_mux;
            end
          end
        end
        default: r_dump_valid <= 1'b0;
      endcase
    end
  end

  assign dout       = r_node[NUM_NODES-1];
  assign rd_data    = r_rd_data;
  assign node_idx   = r_node_idx;
  assign frame_done = r_frame_done;
  assign dump_busy  = (r_state == S_DUMP);
  assign dump_valid = r_dump_valid;
  assign dump_data  = r_dump_data;
  assign dump_idx   = r_dump_idx;

endmodule

// File: tb/tb_reservoir_delay_line.sv
// Scoreboard bench for reservoir_delay_line: frame, load/read, priority,
// stalled dump, clear and reset aborts.
module tb_reservoir_delay_line;

  localparam int N  = 50;
  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst, clear, shift_en, load_en;
  logic          dump_start, dump_ready;
  logic [DW-1:0] din, load_din;
  logic [AW-1:0] load_addr, rd_addr;
  logic [DW-1:0] dout, rd_data, dump_data;
  logic [AW-1:0] node_idx, dump_idx;
  logic          frame_done, dump_busy, dump_valid;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] m [N];
  int            m_idx;
  logic [DW-1:0] q_data [$];
  int            q_idx [$];

  reservoir_delay_line #(.DATA_WIDTH(DW), .NUM_NODES(N)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .shift_en(shift_en), .din(din), .dout(dout),
    .load_en(load_en), .load_addr(load_addr),
    .load_din(load_din), .rd_addr(rd_addr),
    .rd_data(rd_data), .node_idx(node_idx),
    .frame_done(frame_done), .dump_start(dump_start),
    .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_shift(input logic [DW-1:0] d);
    for (int i = N - 1; i > 0; i--)
      m[i] = m[i-1];
    m[0] = d;
    m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_rd"}, rd_data, 0);
    chk({tag, "_idx"}, 32'(node_idx), 0);
    chk({tag, "_fd"}, 32'(frame_done), 0);
    chk({tag, "_busy"}, 32'(dump_busy), 0);
    chk({tag, "_valid"}, 32'(dump_valid), 0);
    chk({tag, "_ddata"}, dump_data, 0);
    chk({tag, "_didx"}, 32'(dump_idx), 0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      q_data.push_back(m[i]);
      step();
      chk(tag, rd_data, q_data.pop_front());
    end
  endtask

  task automatic drain_dump(input string tag);
    int nx;
    nx = 0;
    for (int c = 0; c < 300 && nx < N; c++) begin
      dump_ready = 1'b1;
      if (dump_valid) begin
        chk({tag, "_data"}, dump_data, q_data.pop_front());
        chk({tag, "_idx"}, 32'(dump_idx), 32'(q_idx.pop_front()));
        nx++;
      end
      step();
    end
    dump_ready = 1'b0;
    chk({tag, "_count"}, 32'(nx), 32'(N));
    chk({tag, "_busy_end"}, 32'(dump_busy), 0);
  endtask

  initial begin
    logic [DW-1:0] hd;
    int            hi, nx, nfd;
    logic          hold, hit;

    rst = 1; clear = 0; shift_en = 0; load_en = 0;
    dump_start = 0; dump_ready = 0;
    din = 0; load_din = 0; load_addr = 0; rd_addr = 0;
    for (int i = 0; i < N; i++) m[i] = '0;
    m_idx = 0;
    step(); step();
    rst = 0;
    chk_all_zero("reset");

    nfd = 0;
    for (int k = 0; k < 60; k++) begin
      shift_en = 1; din = DW'(k + 1);
      q_data.push_back(DW'(m_idx == N - 1));
      m_shift(din);
      step();
      chk("frame_done", 32'(frame_done), q_data.pop_front());
      chk("dout_shift", dout, m[N-1]);
      if (frame_done) nfd++;
      if (k == 49) chk("dout_at50", dout, 1);
    end
    shift_en = 0;
    chk("dout_at60", dout, 11);
    chk("frame_pulses", 32'(nfd), 1);
    chk("node_idx_60", 32'(node_idx), 10);

    load_en = 1; load_addr = 7; load_din = 32'hDEADBEEF;
    m[7] = load_din;
    step();
    load_en = 0; rd_addr = 7;
    step();
    chk("rd_7", rd_data, 32'hDEADBEEF);
    rd_addr = 55;
    step();
    chk("rd_oob", rd_data, 0);
    load_en = 1; load_addr = 60; load_din = 32'h1234;
    step();
    load_en = 0;
    read_all("rd_after_oob_load");

    shift_en = 1; load_en = 1; load_addr = 0;
    din = 5; load_din = 9;
    m_shift(din);
    step();
    shift_en = 0; load_en = 0; rd_addr = 0;
    step();
    chk("shift_wins", rd_data, 5);
    chk("node_idx_11", 32'(node_idx), 32'(m_idx));

    for (int i = 0; i < N; i++) begin
      load_en = 1; load_addr = AW'(i); load_din = DW'(3 * i);
      m[i] = load_din;
      step();
    end
    load_en = 0;

    q_data.delete(); q_idx.delete();
    for (int i = 0; i < N; i++) begin
      q_data.push_back(DW'(3 * i));
      q_idx.push_back(i);
    end
    dump_start = 1;
    step();
    dump_start = 0;
    hold = 0; nx = 0; hd = 0; hi = 0;
    for (int c = 0; c < 400 && nx < N; c++) begin
      if (hold) begin
        chk("hold_data", dump_data, hd);
        chk("hold_idx", 32'(dump_idx), 32'(hi));
      end
      chk("busy_in_dump", 32'(dump_busy), 1);
      dump_ready = (c % 2 == 0);
      shift_en = (c % 3 == 0); din = 77;
      dump_start = (c % 7 == 3);
      hold = 0;
      if (dump_valid && dump_ready) begin
        chk("dump_data", dump_data, q_data.pop_front());
        chk("dump_idx", 32'(dump_idx), 32'(q_idx.pop_front()));
        nx++;
      end else if (dump_valid) begin
        hold = 1; hd = dump_data; hi = int'(dump_idx);
      end
      step();
    end
    dump_ready = 0; shift_en = 0; dump_start = 0;
    chk("dump_count", 32'(nx), 32'(N));
    chk("dump_busy_end", 32'(dump_busy), 0);
    chk("dump_valid_end", 32'(dump_valid), 0);
    step();
    chk("dump_no_restart", 32'(dump_busy), 0);
    chk("idx_frozen", 32'(node_idx), 32'(m_idx));
    read_all("rd_after_dump");

    dump_start = 1;
    step();
    dump_start = 0;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      dump_ready = 1;
      if (dump_valid && dump_idx == 20) begin
        clear = 1; dump_ready = 0;
        step();
        clear = 0;
        hit = 1;
        break;
      end
      step();
    end
    chk("clear_reached_20", 32'(hit), 1);
    chk("clear_valid", 32'(dump_valid), 0);
    chk("clear_busy", 32'(dump_busy), 0);
    chk("clear_idx", 32'(node_idx), 0);
    for (int i = 0; i < N; i++) m[i] = '0;
    m_idx = 0;
    read_all("rd_after_clear");

    for (int k = 0; k < 30; k++) begin
      shift_en = 1; din = DW'(100 + k);
      m_shift(din);
      step();
    end
    shift_en = 0;
    chk("idx_30", 32'(node_idx), 32'(m_idx));
    dump_start = 1;
    step();
    dump_start = 0;
    step(); step();
    chk("pre_rst_valid", 32'(dump_valid), 1);
    rst = 1;
    step();
    rst = 0;
    chk_all_zero("rst_mid");

    q_data.delete(); q_idx.delete();
    for (int i = 0; i < N; i++) begin
      q_data.push_back('0);
      q_idx.push_back(i);
    end
    dump_start = 1;
    step();
    dump_start = 0;
    drain_dump("zero_dump");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
